// File: rtl/niosiisystem_gpio_in.sv
// Avalon-MM input PIO: synchronizer, per-bit debounce, edge capture and
// maskable level interrupt, zero-wait-state combinational read.
module niosiisystem_gpio_in #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam int CW = $clog2(DB + 1);
    localparam logic [CW-1:0] CMAX = CW'(DB - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] w1c;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr;
    logic             unused_wd;

    assign wr        = chipselect && !write_n;
    assign unused_wd = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= in_port;
            sync2  <= sync1;
            filt_d <= filt;
            // counter restarts whenever the input agrees with the filter
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CMAX) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = filt & ~filt_d;
    assign fall = ~filt & filt_d;

    always_comb begin
        edges = rise;
        case (EDGE_TYPE)
            1:       edges = fall;
            2:       edges = rise | fall;
            default: edges = rise;
        endcase
    end

    assign w1c = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap     <= '0;
            irqmask <= '0;
        end else begin
            // a new edge wins over a same-cycle clear
            cap <= (cap & ~w1c) | edges;
            if (wr && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0: readdata = 32'(filt);
            2'd1: readdata = '0;
            2'd2: readdata = 32'(irqmask);
            2'd3: readdata = 32'(cap);
        endcase
    end

    assign irq = |(cap & irqmask);

endmodule

// File: tb/tb_niosiisystem_gpio_in.sv
// Randomized and directed bench for niosiisystem_gpio_in, one instance per
// edge type, checked against a cycle-level behavioural model.
module tb_niosiisystem_gpio_in;

    localparam int W  = 16;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cs;
    logic        wn;
    logic [1:0]  address;
    logic [31:0] wd;
    logic [W-1:0] in_port;
    logic [31:0] rdv [3];
    logic        irqv [3];

    always #5 clk = ~clk;

    niosiisystem_gpio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0)) u0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs),
        .write_n(wn), .writedata(wd), .readdata(rdv[0]),
        .in_port(in_port), .irq(irqv[0]));

    niosiisystem_gpio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1)) u1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs),
        .write_n(wn), .writedata(wd), .readdata(rdv[1]),
        .in_port(in_port), .irq(irqv[1]));

    niosiisystem_gpio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2)) u2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(cs),
        .write_n(wn), .writedata(wd), .readdata(rdv[2]),
        .in_port(in_port), .irq(irqv[2]));

    // behavioural model state
    logic [W-1:0] m_s1 = '0;
    logic [W-1:0] m_s2 = '0;
    logic [W-1:0] m_f = '0;
    logic [W-1:0] m_rose = '0;
    logic [W-1:0] m_fell = '0;
    logic [W-1:0] m_mask = '0;
    logic [W-1:0] m_cap [3] = '{default: '0};
    int           m_run [W] = '{default: 0};
    logic [W-1:0] m_clr;
    logic [W-1:0] m_ev;
    logic [W-1:0] m_old;

    int n_chk  = 0;
    int n_pass = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0;
            m_s2 = '0;
            m_f = '0;
            m_rose = '0;
            m_fell = '0;
            m_mask = '0;
            for (int k = 0; k < 3; k++) m_cap[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            m_clr = (cs && !wn && address == 2'd3) ? wd[W-1:0] : '0;
            for (int k = 0; k < 3; k++) begin
                m_ev = (k == 0) ? m_rose : (k == 1) ? m_fell : (m_rose | m_fell);
                m_cap[k] = (m_cap[k] & ~m_clr) | m_ev;
            end
            if (cs && !wn && address == 2'd2) m_mask = wd[W-1:0];
            m_old = m_f;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] != m_f[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DB) begin
                        m_f[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_rose = m_f & ~m_old;
            m_fell = ~m_f & m_old;
            m_s2 = m_s1;
            m_s1 = in_port;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] mread(input int k, input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_f);
            2'd1:    return 32'd0;
            2'd2:    return 32'(m_mask);
            default: return 32'(m_cap[k]);
        endcase
    endfunction

    task automatic cmp_model();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rd%0d_a%0d", k, address), rdv[k], mread(k, address));
            check($sformatf("irq%0d", k), 32'(irqv[k]), 32'(|(m_cap[k] & m_mask)));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        #1;
        cmp_model();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1;
        wn = 1'b0;
        address = a;
        wd = d;
        tick();
        cs = 1'b0;
        wn = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        cs = 1'b0;
        wn = 1'b1;
        address = 2'd0;
        wd = '0;
        in_port = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check($sformatf("rst_a%0d", a), rdv[0], 32'd0);
        end
        check("rst_irq", 32'(irqv[0]), 32'd0);

        repeat (10) tick();
        in_port = 16'h0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) begin
                rd(2'd0);
                check("data_early", rdv[0], 32'd0);
            end
            if (k == 6) begin
                rd(2'd0);
                check("data_lat", rdv[0], 32'd1);
                rd(2'd3);
                check("cap_early", rdv[0], 32'd0);
            end
            if (k == 7) begin
                rd(2'd3);
                check("cap_lat", rdv[0], 32'd1);
                check("irq_masked", 32'(irqv[0]), 32'd0);
            end
        end

        bus_wr(2'd2, 32'h0000_0001);
        check("irq_unmask", 32'(irqv[0]), 32'd1);
        bus_wr(2'd3, 32'h0000_0001);
        check("irq_w1c", 32'(irqv[0]), 32'd0);
        rd(2'd3);
        check("cap_w1c", rdv[0], 32'd0);
        rd(2'd2);
        check("mask_rd", rdv[0], 32'd1);

        in_port[3] = 1'b1;
        repeat (3) tick();
        in_port[3] = 1'b0;
        repeat (10) tick();
        rd(2'd0);
        check("pulse_data", rdv[0], 32'd1);
        rd(2'd3);
        check("pulse_cap", rdv[2], 32'd0);
        for (int t = 0; t < 10; t++) begin
            in_port[3] = ~in_port[3];
            repeat (2) tick();
        end
        repeat (8) tick();
        rd(2'd0);
        check("chatter_data", rdv[0], 32'd1);
        rd(2'd3);
        check("chatter_cap", rdv[2], 32'd0);

        in_port[5] = 1'b1;
        repeat (10) tick();
        in_port[5] = 1'b0;
        repeat (10) tick();
        rd(2'd3);
        check("fall_cap", rdv[1], 32'h20);
        check("rise_cap", rdv[0], 32'h20);
        check("any_cap", rdv[2], 32'h20);
        bus_wr(2'd3, 32'hFFFF_FFFF);

        in_port[2] = 1'b1;
        repeat (6) tick();
        cs = 1'b1;
        wn = 1'b0;
        address = 2'd3;
        wd = 32'h4;
        tick();
        cs = 1'b0;
        wn = 1'b1;
        rd(2'd3);
        check("w1c_race", rdv[0], 32'h4);
        bus_wr(2'd3, 32'h0);
        rd(2'd3);
        check("w1c_zero", rdv[0], 32'h4);
        bus_wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1);
        check("rsvd_rd", rdv[0], 32'd0);
        rd(2'd2);
        check("rsvd_mask", rdv[0], 32'd1);
        rd(2'd3);
        check("rsvd_cap", rdv[0], 32'h4);

        bus_wr(2'd2, 32'h0000_FFFF);
        in_port = 16'hFFFF;
        repeat (10) tick();
        check("pre_rst_irq", 32'(irqv[0]), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check($sformatf("mid_rst_a%0d", a), rdv[0], 32'd0);
        end
        check("mid_rst_irq", 32'(irqv[0]), 32'd0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) begin
                rd(2'd3);
                check("recap_early", rdv[0], 32'd0);
            end
            if (k == 7) begin
                rd(2'd3);
                check("recap", rdv[0], 32'hFFFF);
                check("recap_irq", 32'(irqv[0]), 32'd0);
            end
        end
        bus_wr(2'd2, 32'h0000_FFFF);
        check("remask_irq", 32'(irqv[0]), 32'd1);

        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(99) == 0);
            if ($urandom_range(5) == 0) begin
                in_port = in_port ^ (W'($urandom) & W'($urandom));
            end
            cs = 1'($urandom_range(1));
            wn = 1'($urandom_range(1));
            address = 2'($urandom_range(3));
            wd = $urandom;
            tick();
        end
        reset = 1'b0;
        cs = 1'b0;
        wn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/niosiisystem_gpio_in.md
# niosiisystem_gpio_in

Avalon-MM slave input port for the Nios II system. Samples up to 16 board-level inputs (keys, switches) through a two-flop synchronizer and a per-bit debounce filter. Latches selected edges into a write-1-to-clear capture register and raises a maskable level interrupt to the CPU. Register access is zero-wait-state with combinational readdata, the same slave timing as the system's output PIO.

## Interface
- WIDTH, 16: number of input bits, 1..32.
- DEBOUNCE_CYCLES, 4: consecutive cycles a synchronized bit must differ from its filtered value before the filtered value changes; 0 behaves as 1.
- EDGE_TYPE, 0: edge that sets capture bits; 0 = rising, 1 = falling, 2 = any.

- clk  in  1  system clock; the single clock domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  combinational read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Register map. Reads have no side effects.
  - 0 DATA (RO): filtered value, zero-extended.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK (RW): bits [WIDTH-1:0].
  - 3 EDGECAP (W1C): capture bits.
- Writes occur when chipselect && !write_n at posedge clk. Upper writedata bits beyond WIDTH are ignored.
- Synchronizer: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit i, with counter cnt[i] of width clog2(max(DEBOUNCE_CYCLES,1)+1):
  - If sync2[i] == filt[i]: cnt[i] <= 0.
  - Else if cnt[i] == max(DEBOUNCE_CYCLES,1)-1: filt[i] <= sync2[i] and cnt[i] <= 0.
  - Else cnt[i] <= cnt[i]+1.
- Edge detect: filt_d <= filt.
  - rise = filt & ~filt_d; fall = ~filt & filt_d.
  - edge = rise, fall, or rise|fall according to EDGE_TYPE.
- Capture: cap <= (cap & ~w1c) | edge, where w1c = writedata[WIDTH-1:0] on a write to address 3, else 0.
  - If set and clear hit the same bit in the same cycle, set wins.
  - Bits not written 1 are unchanged.
- irq = |(cap & irqmask), driven combinationally from registers.
- readdata depends on address only, not on chipselect. It reflects the register contents of the current cycle, not the value being written in that cycle.

## Timing
- Reset: sync1, sync2, filt, filt_d, cnt, cap and irqmask all go to 0.
  - readdata = 0 for every address; irq = 0.
  - A bit that is high after reset is treated as a rising transition from 0. It produces a capture once it has been filtered.
- Latency: in_port changes and is stable before edge E0.
  - sync2 updates at E0+1.
  - filt updates at E0+1+max(DEBOUNCE_CYCLES,1).
  - cap sets at the following edge.
  - irq asserts in the same cycle cap sets, if the bit is unmasked.
  - With defaults: DATA changes 5 edges after E0; cap and irq follow at 6 edges.
- A pulse shorter than max(DEBOUNCE_CYCLES,1) cycles at sync2 never reaches filt and captures nothing.
- The counter restarts whenever sync2 returns to the filt value, so chatter keeps filt stable.
- An IRQMASK write takes effect on irq the cycle after the write edge.
- A W1C that clears the last unmasked pending bit drops irq the cycle after the write edge, unless the same bit re-captures in that same cycle.
- Reset asserted mid-debounce discards partial counts and pending captures. irq falls in the cycle following the reset edge.

## Test plan
- Defaults. Hold in_port=0 for 10 cycles after reset, then set bit0=1 and hold → DATA reads 0x1 exactly 5 edges after the change; EDGECAP reads 0x1 at 6 edges; irq stays 0 because the mask is 0.
- Write IRQMASK=0x0001 with bit0 captured → irq=1 next cycle. Write 0x1 to address 3 → EDGECAP=0 and irq=0 next cycle. Reading address 2 returns 0x00000001.
- Pulse bit3 high for 3 cycles with DEBOUNCE_CYCLES=4 → DATA bit3 and EDGECAP stay 0. Toggle bit3 every 2 cycles for 20 cycles → no change.
- EDGE_TYPE=1. Drive bit5 1 then 0 (each held 10 cycles) → only the falling edge captures, giving EDGECAP=0x20. With EDGE_TYPE=2 → two captures; the second arrives while bit5 is set and leaves it set.
- Time a W1C of bit2 to the exact cycle bit2's edge is detected → bit2 remains 1 after the write. A W1C of 0x0 leaves all bits unchanged. Writes to address 1 do not change any register.
- Assert reset for 1 cycle while in_port=0xFFFF, IRQMASK=0xFFFF and captures are pending → all reads 0 and irq=0 the next cycle. EDGECAP=0xFFFF 6 edges after reset deasserts; irq stays 0 until the mask is rewritten.
